param_dpll: RTL and testbench

PARAM_DPLL -- requirements
Module: param_dpll

---
 rtl/dpll_pkg.sv | 17 +
 rtl/dpll_loop_filter.sv | 60 ++++++
 rtl/param_dpll.sv | 125 ++++++++++++
 tb/tb_param_dpll.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared types and default parameter values for the param_dpll block.
package dpll_pkg;

    localparam int DIV_W_DEF    = 7;
    localparam int FILTER_K_DEF = 8;
    localparam int LOCK_CNT_DEF = 16;

    // Accumulator width: holds +/-(FILTER_K-1) for any FILTER_K up to 127.
    localparam int ACC_W = 8;

    typedef enum logic [1:0] {
        PE_NONE = 2'd0,
        PE_LEAD = 2'd1,
        PE_LAG  = 2'd2
    } phase_err_e;

endpackage

// File: rtl/dpll_loop_filter.sv
// Loop filter for param_dpll: signed accumulator of phase-error votes.
// Reaching +/-FILTER_K clears the accumulator and emits a one-cycle
// advance/retard pulse on the following cycle.
module dpll_loop_filter
    import dpll_pkg::*;
#(
    parameter int FILTER_K = FILTER_K_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  phase_err_e pe_i,
    output logic       advance_o,
    output logic       retard_o
);

    localparam logic signed [ACC_W-1:0] K_POS = ACC_W'(FILTER_K);
    localparam logic signed [ACC_W-1:0] K_NEG = -K_POS;
    localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic                    adv_q, adv_d;
    logic                    ret_q, ret_d;

    // Next accumulator value and threshold detection.
    always_comb begin
        acc_sum = acc_q;
        unique case (pe_i)
            PE_LAG:  acc_sum = acc_q + ONE;
            PE_LEAD: acc_sum = acc_q - ONE;
            default: acc_sum = acc_q;
        endcase
        acc_d = acc_sum;
        adv_d = 1'b0;
        ret_d = 1'b0;
        if (acc_sum == K_POS) begin
            acc_d = '0;
            adv_d = 1'b1;
        end else if (acc_sum == K_NEG) begin
            acc_d = '0;
            ret_d = 1'b1;
        end
    end

    // Accumulator and pulse registers; reset drops any pending pulse.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            acc_q <= '0;
            adv_q <= 1'b0;
            ret_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            adv_q <= adv_d;
            ret_q <= ret_d;
        end
    end

    assign advance_o = adv_q;
    assign retard_o  = ret_q;

endmodule

// File: rtl/param_dpll.sv
// Digital PLL recovering a divided clock aligned to an oversampled
// reference. Phase counter runs 0..N-1; the loop filter nudges it by
// one extra or one skipped step. Optional lock detector is built only
// when PARAM_DPLL_LOCK_DETECT_EN is defined; otherwise locked_o is 0.
module param_dpll
    import dpll_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int FILTER_K = FILTER_K_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             signal_i,
    input  logic [DIV_W-1:0] divFactor_i,
    output logic             signal_o,
    output logic             locked_o,
    output logic             advance_o,
    output logic             retard_o
);

    // Reject parameter sets the datapath widths cannot represent.
    if (DIV_W < 2 || FILTER_K < 2 || FILTER_K > 127 || LOCK_CNT < 1) begin : g_bad_params
        $error("param_dpll: parameter out of range");
    end

    logic             sig_r_q, sig_rr_q;
    logic             ref_rise;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] div_sat;
    logic [DIV_W-1:0] half;
    logic [DIV_W:0]   cnt_sum;
    logic [1:0]       step;
    logic             wrap;
    phase_err_e       pe;

    assign ref_rise = sig_r_q & ~sig_rr_q;
    assign div_sat  = (divFactor_i < DIV_W'(2)) ? DIV_W'(2) : divFactor_i;
    assign half     = n_q >> 1;
    assign signal_o = (cnt_q < half);

    // Phase step and wrap; N only reloads at the period boundary.
    always_comb begin
        step = advance_o ? 2'd2 : (retard_o ? 2'd0 : 2'd1);
        cnt_sum = {1'b0, cnt_q} + {{(DIV_W-1){1'b0}}, step};
        wrap = (cnt_sum >= {1'b0, n_q});
        cnt_d = wrap ? DIV_W'(cnt_sum - {1'b0, n_q}) : cnt_sum[DIV_W-1:0];
        n_d = wrap ? div_sat : n_q;
    end

    // Classify each reference rising edge against the current phase.
    always_comb begin
        pe = PE_NONE;
        if (ref_rise && (cnt_q != '0)) begin
            pe = (cnt_q < half) ? PE_LEAD : PE_LAG;
        end
    end

    // Input synchroniser, phase counter and latched divider.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sig_r_q  <= 1'b0;
            sig_rr_q <= 1'b0;
            cnt_q    <= '0;
            n_q      <= div_sat;
        end else begin
            sig_r_q  <= signal_i;
            sig_rr_q <= sig_r_q;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
        end
    end

    dpll_loop_filter #(
        .FILTER_K (FILTER_K)
    ) u_loop_filter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .pe_i      (pe),
        .advance_o (advance_o),
        .retard_o  (retard_o)
    );

`ifdef PARAM_DPLL_LOCK_DETECT_EN
    localparam int               LK_W  = $clog2(LOCK_CNT + 1);
    localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_CNT);

    logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic             locked_q;
    logic             in_win;
    logic [DIV_W-1:0] n_m1;

    assign n_m1   = n_q - DIV_W'(1);
    assign in_win = (cnt_q == n_m1) || (cnt_q == '0) || (cnt_q == DIV_W'(1));

    // Count consecutive in-window edges, saturating; any miss restarts.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (ref_rise) begin
            if (!in_win) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LK_MAX) begin
                lock_cnt_d = lock_cnt_q + LK_W'(1);
            end
        end
    end

    // Lock counter and registered lock flag tracking its saturation.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= (lock_cnt_d == LK_MAX);
        end
    end

    assign locked_o = locked_q;
`else
    assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_param_dpll.sv
// Directed bench for param_dpll with N=10, FILTER_K=4, LOCK_CNT=8.
// Expectations on locked_o follow PARAM_DPLL_LOCK_DETECT_EN.
module tb_param_dpll;

`ifdef PARAM_DPLL_LOCK_DETECT_EN
    localparam logic LK = 1'b1;
`else
    localparam logic LK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       signal_i = 1'b0;
    logic [6:0] divFactor_i = 7'd10;
    logic       signal_o, locked_o, advance_o, retard_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    param_dpll #(
        .DIV_W    (7),
        .FILTER_K (4),
        .LOCK_CNT (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .signal_i    (signal_i),
        .divFactor_i (divFactor_i),
        .signal_o    (signal_o),
        .locked_o    (locked_o),
        .advance_o   (advance_o),
        .retard_o    (retard_o)
    );

    // ph: cycle of first reference rise (period 10), -1 = no reference.
    typedef struct {
        int rst_cyc;
        int div0;
        int ph;
        int cycles;
        int chg_cyc;
        int new_div;
        int n_adv;
        int n_ret;
    } scen_t;

    typedef struct {
        int   scen;
        int   cyc;
        logic sig;
        logic adv;
        logic ret;
        logic lck;
    } vec_t;

    scen_t scens[8];
    vec_t  vecs[$];

    logic obs_sig[0:127];
    logic obs_adv[0:127];
    logic obs_ret[0:127];
    logic obs_lck[0:127];

    task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int idx, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input int s, input int c, input logic sg, input logic ad, input logic rt, input logic lk);
        vec_t v;
        v.scen = s; v.cyc = c; v.sig = sg; v.adv = ad; v.ret = rt; v.lck = lk;
        vecs.push_back(v);
    endtask

    // Value driven during cycle j, sampled at the edge starting cycle j+1.
    function automatic logic pat(input int j, input int ph);
        if (ph < 0) return 1'b0;
        if (j + 1 < ph) return 1'b0;
        return (((j + 1 - ph) % 10) < 5);
    endfunction

    task automatic run_scen(input int s);
        scen_t sc;
        int    n_adv, n_ret, n_both;
        sc = scens[s];
        n_adv = 0; n_ret = 0; n_both = 0;
        reset_i = 1'b0;
        divFactor_i = 7'(sc.div0);
        signal_i = 1'b1;
        for (int r = 0; r < sc.rst_cyc; r++) begin
            @(negedge clk);
            check_bit("rst_signal_o", s, signal_o, 1'b1);
            check_bit("rst_locked_o", s, locked_o, 1'b0);
            check_bit("rst_advance_o", s, advance_o, 1'b0);
            check_bit("rst_retard_o", s, retard_o, 1'b0);
            signal_i = ~signal_i;
        end
        obs_sig[0] = signal_o; obs_adv[0] = advance_o;
        obs_ret[0] = retard_o; obs_lck[0] = locked_o;
        reset_i = 1'b1;
        signal_i = pat(0, sc.ph);
        for (int k = 1; k <= sc.cycles; k++) begin
            @(negedge clk);
            obs_sig[k] = signal_o; obs_adv[k] = advance_o;
            obs_ret[k] = retard_o; obs_lck[k] = locked_o;
            if (advance_o) n_adv++;
            if (retard_o) n_ret++;
            if (advance_o && retard_o) n_both++;
            if (k == sc.chg_cyc) divFactor_i = 7'(sc.new_div);
            signal_i = pat(k, sc.ph);
        end
        check_int("advance_pulses", s, n_adv, sc.n_adv);
        check_int("retard_pulses", s, n_ret, sc.n_ret);
        check_int("both_pulses", s, n_both, 0);
        foreach (vecs[i]) begin
            if (vecs[i].scen == s) begin
                check_bit("signal_o", vecs[i].cyc, obs_sig[vecs[i].cyc], vecs[i].sig);
                check_bit("advance_o", vecs[i].cyc, obs_adv[vecs[i].cyc], vecs[i].adv);
                check_bit("retard_o", vecs[i].cyc, obs_ret[vecs[i].cyc], vecs[i].ret);
                check_bit("locked_o", vecs[i].cyc, obs_lck[vecs[i].cyc], vecs[i].lck);
            end
        end
    endtask

    initial begin
        //            rst div  ph  cyc chg new adv ret
        scens[0] = '{5, 10, -1, 40, -1,  0, 0, 0};  // idle reference
        scens[1] = '{2, 10, 10, 89, -1,  0, 0, 0};  // aligned, locks
        scens[2] = '{1, 10, 10, 89, -1,  0, 0, 0};  // reset after lock, relock
        scens[3] = '{2, 10,  7, 45, -1,  0, 1, 0};  // lag -> advance
        scens[4] = '{2, 10,  3, 40, -1,  0, 0, 1};  // lead -> retard
        scens[5] = '{2, 10, -1, 40, 13, 12, 0, 0};  // divider change at cnt=3
        scens[6] = '{2, 10,  7, 37, -1,  0, 0, 0};  // lag, cut before the pulse
        scens[7] = '{1, 10,  7, 45, -1,  0, 1, 0};  // reset drops the pending pulse

        add(0,  0, 1, 0, 0, 0); add(0,  4, 1, 0, 0, 0); add(0,  5, 0, 0, 0, 0);
        add(0,  9, 0, 0, 0, 0); add(0, 10, 1, 0, 0, 0); add(0, 14, 1, 0, 0, 0);
        add(0, 15, 0, 0, 0, 0); add(0, 19, 0, 0, 0, 0); add(0, 20, 1, 0, 0, 0);
        add(1, 79, 0, 0, 0, 0); add(1, 80, 1, 0, 0, 0); add(1, 81, 1, 0, 0, LK);
        add(1, 89, 0, 0, 0, LK);
        add(2,  0, 1, 0, 0, 0); add(2, 80, 1, 0, 0, 0); add(2, 81, 1, 0, 0, LK);
        add(3, 37, 0, 0, 0, 0); add(3, 38, 0, 1, 0, 0); add(3, 39, 1, 0, 0, 0);
        add(3, 40, 1, 0, 0, 0); add(3, 44, 0, 0, 0, 0);
        add(4, 33, 1, 0, 0, 0); add(4, 34, 1, 0, 1, 0); add(4, 35, 1, 0, 0, 0);
        add(4, 36, 0, 0, 0, 0); add(4, 40, 0, 0, 0, 0);
        add(5, 14, 1, 0, 0, 0); add(5, 15, 0, 0, 0, 0); add(5, 19, 0, 0, 0, 0);
        add(5, 20, 1, 0, 0, 0); add(5, 25, 1, 0, 0, 0); add(5, 26, 0, 0, 0, 0);
        add(5, 31, 0, 0, 0, 0); add(5, 32, 1, 0, 0, 0); add(5, 37, 1, 0, 0, 0);
        add(5, 38, 0, 0, 0, 0);
        add(6, 36, 0, 0, 0, 0); add(6, 37, 0, 0, 0, 0);
        add(7,  0, 1, 0, 0, 0); add(7, 37, 0, 0, 0, 0); add(7, 38, 0, 1, 0, 0);
        add(7, 39, 1, 0, 0, 0);

        for (int s = 0; s < 8; s++) begin
            run_scen(s);
        end

        // Divider below 2 behaves as N=2: signal_o alternates every cycle.
        reset_i = 1'b0;
        signal_i = 1'b0;
        divFactor_i = 7'd1;
        repeat (2) @(negedge clk);
        check_bit("min_div_signal_o", 0, signal_o, 1'b1);
        reset_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_bit("min_div_signal_o", k, signal_o, (k % 2) == 0);
            if (k == 2) divFactor_i = 7'd0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
